mul_seq: RTL and testbench

- Iterative radix-2 shift-add multiplier; the multiplication counterpart of the team's sequential divider.
- Shares the divider's start/flush/ready handshake, so the execute stage drives both units the same way.
- Computes the full 2*DATA_WIDTH product. Operand signedness is selected independently, covering MUL/MULH/MULHSU/MULHU.
- One partial product per clock.

---
 rtl/mul_seq_if.sv | 29 ++
 rtl/mul_seq.sv | 91 +++++++++
 tb/tb_mul_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_if.sv
// Operand/result bundle for the sequential multiplier, shared with the divider handshake.
// Latency: not applicable (pure wiring).
// Backpressure: start is accepted at any time; ready tells the driver when the result is held.
interface mul_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic                  a_signed;
  logic                  b_signed;
  logic                  start;
  logic                  flush;
  logic [DATA_WIDTH-1:0] product_lo;
  logic [DATA_WIDTH-1:0] product_hi;
  logic                  ready;
  logic                  valid;

  // Execute stage side: drives operands and commands, observes the result.
  modport master (
    output multiplicand, multiplier, a_signed, b_signed, start, flush,
    input  product_lo, product_hi, ready, valid
  );

  // Multiplier side.
  modport slave (
    input  multiplicand, multiplier, a_signed, b_signed, start, flush,
    output product_lo, product_hi, ready, valid
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier producing the full 2*DATA_WIDTH product, any operand signedness.
// Latency: DATA_WIDTH cycles from an accepted start to ready/valid; one partial product per clock.
// Backpressure: none; start restarts at any time, flush abandons, result holds until next start/flush.
module mul_seq #(
  parameter int DATA_WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [CW-1:0]         count;
  logic                  a_sgn;
  logic                  b_sgn;
  logic                  ready;
  logic                  valid;

  logic                  last;
  logic                  sub_step;
  logic [DATA_WIDTH:0]   addend;
  logic [DATA_WIDTH:0]   sum;
  logic                  shift_in;

  // Partial-product step: add (or subtract on the final signed-B step) A, then pick the shift-in bit.
  always_comb begin
    last     = (count == CW'(DATA_WIDTH - 1));
    sub_step = last && b_sgn && lo[0];
    addend   = '0;
    if (lo[0]) begin
      addend = sub_step ? -a_ext : a_ext;
    end
    sum = hi + addend;
    // With unsigned A and an addition, the top sum bit is magnitude (sum is never negative),
    // so the shift fills with zero; otherwise the sum fits as a signed value and its sign fills.
    shift_in = (a_sgn || sub_step) ? sum[DATA_WIDTH] : 1'b0;
  end

  // Control FSM and datapath registers; priority rst > flush > start > iterate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_ext <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
        ready <= 1'b1;
        count <= '0;
      end else if (bus.start) begin
        state <= BUSY;
        ready <= 1'b0;
        a_ext <= bus.a_signed ? {bus.multiplicand[DATA_WIDTH-1], bus.multiplicand}
                              : {1'b0, bus.multiplicand};
        a_sgn <= bus.a_signed;
        b_sgn <= bus.b_signed;
        hi    <= '0;
        lo    <= bus.multiplier;
        count <= '0;
      end else if (state == BUSY) begin
        hi    <= {shift_in, sum[DATA_WIDTH:1]};
        lo    <= {sum[0], lo[DATA_WIDTH-1:1]};
        count <= count + 1'b1;
        if (last) begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b1;
          count <= '0;
        end
      end
    end
  end

  assign bus.product_hi = hi[DATA_WIDTH-1:0];
  assign bus.product_lo = lo;
  assign bus.ready      = ready;
  assign bus.valid      = valid;
endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corners, random operands, flush, restart, async reset.
// Latency: checks ready stays low exactly W cycles per operation.
// Backpressure: exercises restart-while-busy and start-on-completion.
module tb_mul_seq;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_seq_if #(.DATA_WIDTH(W)) bus ();

  mul_seq #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product of the operands under the chosen interpretation, modulo 2^(2W).
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit as, input bit bs);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = as ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = bs ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Present a start for one clock; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit as, input bit bs);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.a_signed     = as;
    bus.b_signed     = bs;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // From the negedge after the accepting edge, count busy cycles and valid pulses until done.
  task automatic wait_done(output logic [2*W-1:0] prod, output int low, output int pulses,
                           output bit timeout);
    low     = 0;
    pulses  = 0;
    timeout = 1'b0;
    while (!bus.ready && low < 200) begin
      low++;
      if (bus.valid) pulses++;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
      bus.a_signed     = 1'($urandom);
      bus.b_signed     = 1'($urandom);
      @(negedge clk);
    end
    if (!bus.ready) timeout = 1'b1;
    prod = {bus.product_hi, bus.product_lo};
    if (bus.valid) pulses++;
    @(negedge clk);
    if (bus.valid) pulses++;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit as, input bit bs);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] exp;
    int low, pulses;
    bit to;
    exp = ref_mul(a, b, as, bs);
    issue(a, b, as, bs);
    wait_done(prod, low, pulses, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout: ready never rose", name);
    end
    checks++;
    if (prod !== exp) begin
      errors++;
      $display("FAIL %s product got %h expected %h", name, prod, exp);
    end
    checks++;
    if (low !== W) begin
      errors++;
      $display("FAIL %s busy cycles got %0d expected %0d", name, low, W);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL %s valid pulses got %0d expected 1", name, pulses);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ready/valid got %b%b expected 10", bus.ready, bus.valid);
    end
    checks++;
    if ({bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL reset_product got %h expected 0", {bus.product_hi, bus.product_lo});
    end
  endtask

  task automatic test_corners;
    check_op("umax",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_op("s_m1_m1",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    check_op("s_min_min",  32'h80000000, 32'h80000000, 1'b1, 1'b1);
    check_op("mulhsu",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    check_op("mulhus",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    check_op("zero",       32'h00000000, 32'h12345678, 1'b1, 1'b1);
    check_op("umin_smax",  32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      check_op("random", $urandom, $urandom, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_flush_idle;
    @(negedge clk);
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    bus.start        = 1'b1;
    bus.flush        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle ready got %b expected 1", bus.ready);
    end
  endtask

  task automatic test_flush;
    int pulses;
    issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush ready/valid got %b%b expected 10", bus.ready, bus.valid);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL flush_no_valid pulses got %0d expected 0", pulses);
    end
    check_op("after_flush", 32'd7, 32'd6, 1'b0, 1'b0);
  endtask

  task automatic test_restart;
    logic [2*W-1:0] prod;
    int low, pulses, early;
    bit to;
    early = 0;
    issue(32'd100, 32'd200, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.valid) early++;
    end
    issue(32'd3, 32'd5, 1'b0, 1'b0);
    wait_done(prod, low, pulses, to);
    checks++;
    if (to || prod !== ref_mul(32'd3, 32'd5, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL restart product got %h expected %h", prod, ref_mul(32'd3, 32'd5, 1'b0, 1'b0));
    end
    checks++;
    if (low !== W || pulses + early !== 1) begin
      errors++;
      $display("FAIL restart timing busy %0d pulses %0d expected %0d and 1", low, pulses + early, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] prod;
    int low, pulses;
    bit to;
    issue(32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0);
    repeat (W - 1) @(negedge clk);
    bus.multiplicand = 32'hFFFFFFF9;
    bus.multiplier   = 32'd11;
    bus.a_signed     = 1'b1;
    bus.b_signed     = 1'b0;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_completion ready/valid got %b%b expected 00", bus.ready, bus.valid);
    end
    wait_done(prod, low, pulses, to);
    checks++;
    if (to || prod !== ref_mul(32'hFFFFFFF9, 32'd11, 1'b1, 1'b0) || low !== W || pulses !== 1) begin
      errors++;
      $display("FAIL b2b_second product %h busy %0d pulses %0d expected %h %0d 1",
               prod, low, pulses, ref_mul(32'hFFFFFFF9, 32'd11, 1'b1, 1'b0), W);
    end
  endtask

  task automatic test_async_reset;
    issue(32'h0BADF00D, 32'h13579BDF, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || {bus.product_hi, bus.product_lo} !== '0) begin
      errors++;
      $display("FAIL async_reset ready %b valid %b product %h expected 1 0 0",
               bus.ready, bus.valid, {bus.product_hi, bus.product_lo});
    end
    @(negedge clk);
    rst = 1'b0;
    check_op("after_reset", 32'h00010000, 32'h00010000, 1'b0, 1'b0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.a_signed     = 1'b0;
    bus.b_signed     = 1'b0;
    bus.start        = 1'b0;
    bus.flush        = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_corners;
    test_random;
    test_flush_idle;
    test_flush;
    test_restart;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
